// File: rtl/spram_ctl.sv
// Byte-addressed load/store controller in front of a 32K x 32 single-port SPRAM.
// Define SPRAM_CTL_SPLIT_EN to run word-crossing accesses as two SPRAM cycles; otherwise they are rejected with err.
module spram_ctl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  sz,
   input  logic [16:0] addr,
   input  logic [31:0] wdat,
   output logic        rdy,
   output logic        ack,
   output logic        err,
   output logic [31:0] rdat,
   output logic        mem_we,
   output logic [3:0]  mem_bmsk,
   output logic [14:0] mem_a,
   output logic [31:0] mem_vi,
   input  logic [31:0] mem_vo
);

`ifdef SPRAM_CTL_SPLIT_EN
   localparam logic SPLIT_EN = 1'b1;
`else
   localparam logic SPLIT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_A0, S_A1, S_CAP, S_DONE} state_t;

   function automatic logic [31:0] size_mask(input logic [1:0] s);
      case (s)
         2'd0:    return 32'h0000_00FF;
         2'd1:    return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic logic [7:0] lane_mask(input logic [1:0] s, input logic [1:0] off);
      logic [7:0] m;
      case (s)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         default: m = 8'h0F;
      endcase
      return m << off;
   endfunction

   function automatic logic [63:0] store_vec(input logic [1:0] s, input logic [1:0] off,
                                             input logic [31:0] d);
      logic [63:0] v;
      v = {32'b0, d & size_mask(s)};
      return v << {off, 3'b000};
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] w1, input logic [31:0] w0,
                                                input logic [1:0] s, input logic [1:0] off);
      logic [63:0] v;
      v = {w1, w0} >> {off, 3'b000};
      return v[31:0] & size_mask(s);
   endfunction

   state_t      state_q, state_d;
   logic        rdy_q, rdy_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [31:0] rdat_q, rdat_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_bmsk_q, mem_bmsk_d;
   logic [14:0] mem_a_q, mem_a_d;
   logic [31:0] mem_vi_q, mem_vi_d;

   // Request latched at acceptance; word-1 lanes and data are precomputed here.
   logic        wr_q;
   logic [1:0]  sz_q;
   logic [16:0] addr_q;
   logic [3:0]  lm_hi_q;
   logic [31:0] s_hi_q;
   logic [31:0] w0_q;

   logic [7:0]  lm_i;
   logic [63:0] s_i;
   logic        split_i, split_q, accept, reject;

   assign lm_i    = lane_mask(sz, addr[1:0]);
   assign s_i     = store_vec(sz, addr[1:0], wdat);
   assign split_i = |lm_i[7:4];
   assign split_q = |lm_hi_q;
   assign accept  = req && (state_q == S_IDLE || state_q == S_DONE);
   assign reject  = split_i && !SPLIT_EN;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rdy_q      <= 1'b1;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdat_q     <= '0;
         mem_we_q   <= 1'b0;
         mem_bmsk_q <= '0;
         mem_a_q    <= '0;
         mem_vi_q   <= '0;
      end else begin
         state_q    <= state_d;
         rdy_q      <= rdy_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdat_q     <= rdat_d;
         mem_we_q   <= mem_we_d;
         mem_bmsk_q <= mem_bmsk_d;
         mem_a_q    <= mem_a_d;
         mem_vi_q   <= mem_vi_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         wr_q    <= wr;
         sz_q    <= sz;
         addr_q  <= addr;
         lm_hi_q <= lm_i[7:4];
         s_hi_q  <= s_i[63:32];
      end
      if (state_q == S_A1) w0_q <= mem_vo;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) state_d = reject ? S_DONE : S_A0;
            else        state_d = S_IDLE;
         end
         S_A0:    state_d = split_q ? S_A1 : (wr_q ? S_DONE : S_CAP);
         S_A1:    state_d = wr_q ? S_DONE : S_CAP;
         S_CAP:   state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are computed one state ahead so every port comes straight from a flop.
   always_comb begin
      rdy_d      = (state_d == S_IDLE) || (state_d == S_DONE);
      ack_d      = 1'b0;
      err_d      = 1'b0;
      rdat_d     = rdat_q;
      mem_we_d   = 1'b0;
      mem_bmsk_d = '0;
      mem_a_d    = mem_a_q;
      mem_vi_d   = mem_vi_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept && reject) begin
               ack_d  = 1'b1;
               err_d  = 1'b1;
               rdat_d = '0;
            end else if (accept) begin
               mem_we_d   = wr;
               mem_bmsk_d = lm_i[3:0];
               mem_a_d    = addr[16:2];
               mem_vi_d   = s_i[31:0];
            end
         end
         S_A0: begin
            if (split_q) begin
               mem_we_d   = wr_q;
               mem_bmsk_d = lm_hi_q;
               mem_a_d    = addr_q[16:2] + 15'd1;
               mem_vi_d   = s_hi_q;
            end else if (wr_q) begin
               ack_d  = 1'b1;
               rdat_d = '0;
            end
         end
         S_A1: begin
            if (wr_q) begin
               ack_d  = 1'b1;
               rdat_d = '0;
            end
         end
         S_CAP: begin
            ack_d  = 1'b1;
            rdat_d = split_q ? load_extract(mem_vo, w0_q, sz_q, addr_q[1:0])
                             : load_extract(32'b0, mem_vo, sz_q, addr_q[1:0]);
         end
         default: ;
      endcase
   end

   assign rdy      = rdy_q;
   assign ack      = ack_q;
   assign err      = err_q;
   assign rdat     = rdat_q;
   assign mem_we   = mem_we_q;
   assign mem_bmsk = mem_bmsk_q;
   assign mem_a    = mem_a_q;
   assign mem_vi   = mem_vi_q;

endmodule

// File: doc/spram_ctl.md
# spram_ctl

Byte-addressed access controller that acts as the initiator for the 32-bit single-port SPRAM array (32K words × 32 bits, synchronous read, per-byte write mask). It turns byte/halfword/word load and store requests from the Forth core into SPRAM cycles. It handles lane placement, read-data extraction and zero-extension, and splits unaligned accesses that cross a word boundary into two back-to-back SPRAM cycles. It sits between the core's data port and the SPRAM instance.

## Interface
Parameters: none (geometry is fixed at 17-bit byte address, 15-bit word address, 32-bit data).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request valid; sampled only when rdy=1
- wr  in  1  1 = store, 0 = load
- sz  in  2  0 = byte, 1 = halfword, 2 = word, 3 = treated as word
- addr  in  17  byte address
- wdat  in  32  store data, right-justified
- rdy  out  1  controller idle, accepting req
- ack  out  1  one-cycle completion pulse
- err  out  1  qualifies ack: request rejected
- rdat  out  32  load data, right-justified, zero-extended; valid when ack=1
- mem_we  out  1  SPRAM write enable
- mem_bmsk  out  4  SPRAM byte mask; bit k selects bits [8k+7:8k]
- mem_a  out  15  SPRAM word address
- mem_vi  out  32  SPRAM write data
- mem_vo  in  32  SPRAM read data, valid in the cycle after mem_a is presented

## Operation
- Offset: off = addr[1:0]. Size mask: m = 1 (byte), 3 (half), F (word).
- Lane mask: 8-bit lm = m << off. Word-0 mask = lm[3:0] at word addr[16:2]. Word-1 mask = lm[7:4] at word addr[16:2]+1, modulo 32768 (word 32767 wraps to word 0).
- split = |lm[7:4].
- Store data: 64-bit s = ({32'b0, wdat masked to size}) << 8*off. Word 0 uses mem_vi = s[31:0]; word 1 uses s[63:32].
- Load data: capture w0, then w1 if split. rdat = ({w1, w0} >> 8*off) masked to size, upper bits zero.
- States:
  - IDLE: rdy=1. On req, latch wr/sz/addr/wdat and go to A0.
  - A0: drive word 0. Go to A1 if split, else go to CAP (load) or DONE (store).
  - A1: drive word 1 and capture w0 from mem_vo. Go to CAP (load) or DONE (store).
  - CAP: capture the last read word from mem_vo, then go to DONE.
  - DONE: ack=1 and rdy=1. This state behaves as IDLE, so a new req is accepted in the same cycle.
- mem_we=1 only in A0/A1 of a store. Outside A0/A1, mem_we=0 and mem_bmsk=0.
- req while rdy=0 is ignored, not queued. The requester holds req until accepted.

## Timing
- Reset values: state IDLE, rdy=1, ack=0, err=0, rdat=0, mem_we=0, mem_bmsk=0, mem_a=0, mem_vi=0.
- All mem_* outputs and rdat/ack/err are registered.
- Latency from the acceptance edge T0 to ack:
  - aligned store: T2
  - aligned load: T3
  - split store: T3
  - split load: T4
- Throughput: aligned back-to-back stores complete one per 2 cycles.
- Reset mid-operation: outputs clear immediately. A split store interrupted after A0 leaves word 1 unwritten. No ack is issued for the aborted request.

## Configuration
- SPRAM_CTL_SPLIT_EN defined: split accesses run as two SPRAM cycles, as above.
- SPRAM_CTL_SPLIT_EN undefined:
  - A split request goes IDLE → DONE with ack=1, err=1 and rdat=0 at T1.
  - No SPRAM cycle is issued.
  - Non-split behaviour is identical to the defined case.
  - err is 0 in both builds for every non-split request.

## Test plan
- Byte store 0xA5 at addr 0x00005 → T1: mem_a=1, mem_bmsk=0010, mem_we=1, mem_vi[15:8]=A5. T2: ack=1, err=0.
- Word store 0x11223344 at 0x00004, then word load at 0x00004 → ack at T3 with rdat=0x11223344. Then byte load at 0x00006 → rdat=0x00000022.
- Split word store 0x11223344 at 0x00003:
  - T1: mem_a=0, bmsk=1000, vi[31:24]=44.
  - T2: mem_a=1, bmsk=0111, vi[23:0]=112233.
  - T3: ack=1.
  - Word load at 0x00003 → rdat=0x11223344 at T4.
- Wrap: half store 0xBEEF at 0x1FFFF → T1: mem_a=0x7FFF, bmsk=1000. T2: mem_a=0x0000, bmsk=0001. Load back → rdat=0x0000BEEF.
- Build without SPRAM_CTL_SPLIT_EN: word store at 0x00001 → T1: ack=1, err=1, mem_we never asserted. Aligned requests behave unchanged.
- Assert rst_n=0 during A1 of a split store → mem_we=0 and rdy=1 immediately, no ack; the word-1 location keeps its old value.
